// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Pulls words from a synchronous FIFO with a fixed 1-cycle read latency and
//   presents them as a valid/ready stream through a 2-entry in-order skid
//   buffer. Sustains one word per cycle when the FIFO has data and the
//   downstream is ready.
//
// Ports
//   clk           rising-edge clock shared with the FIFO
//   rst_          asynchronous active-low reset
//   en            1 = fetch from the FIFO, 0 = stop fetching and drain
//   fifo_empty    FIFO empty indicator
//   fifo_data_out FIFO read data, valid the cycle after an accepted read
//   fifo_read     read request to the FIFO (combinational)
//   out_valid     stream data valid
//   out_ready     downstream ready
//   out_data      stream data (head of the local buffer)
//   busy          high whenever the reader is not idle
//   word_cnt      number of words delivered on the stream (wraps)
module fifo_stream_reader #(
  parameter int width    = 16,
  parameter int cnt_bits = 16
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                en,
  input  logic                fifo_empty,
  input  logic [width-1:0]    fifo_data_out,
  output logic                fifo_read,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [width-1:0]    out_data,
  output logic                busy,
  output logic [cnt_bits-1:0] word_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [1:0]         occ;
  logic               inflight;
  logic [width-1:0]   buf0, buf1;
  logic               pop;
  logic [2:0]         pending;

  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = buf0;
  assign busy      = (state != IDLE);

  // Slots that will be occupied once the in-flight word lands and the current
  // pop retires; a new read is only issued if that leaves room for it.
  assign pending   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_read = (state == ACTIVE) && en && !fifo_empty && (pending < 3'd2);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!en) begin
          if (occ == 2'd0 && !inflight) state_nxt = IDLE;
          else                          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (occ == 2'd0 && !inflight) state_nxt = en ? ACTIVE : IDLE;
        else if (en)                  state_nxt = ACTIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Skid buffer: buf0 is the head. A word arriving from the FIFO lands in the
  // first free slot after any simultaneous pop has shifted buf1 forward.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= fifo_read;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_data_out;
          else             buf1 <= fifo_data_out;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            buf0 <= buf1;
            buf1 <= fifo_data_out;
          end else begin
            buf0 <= fifo_data_out;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      word_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + {{(cnt_bits-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_;
  logic        en;
  logic        fifo_empty;
  logic [15:0] fifo_data_out;
  logic        fifo_read;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic [15:0] word_cnt;

  // second instance with a 4-bit counter, fed by an always-full FIFO
  logic        en2;
  logic        ready2;
  logic        fifo_read2;
  logic        out_valid2;
  logic [15:0] out_data2;
  logic        busy2;
  logic [3:0]  word_cnt2;
  logic [15:0] data2 = 16'hA5A5;
  logic        empty2 = 1'b0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.width(16), .cnt_bits(16)) u_dut (
    .clk(clk), .rst_(rst_), .en(en), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_read(fifo_read),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .word_cnt(word_cnt)
  );

  fifo_stream_reader #(.width(16), .cnt_bits(4)) u_wrap (
    .clk(clk), .rst_(rst_), .en(en2), .fifo_empty(empty2),
    .fifo_data_out(data2), .fifo_read(fifo_read2),
    .out_valid(out_valid2), .out_ready(ready2), .out_data(out_data2),
    .busy(busy2), .word_cnt(word_cnt2)
  );

  // FIFO model: 1-cycle read latency
  logic [15:0] mem [0:255];
  int wp = 0;
  int rp = 0;
  logic flush = 1'b0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (flush) rp <= wp;
    else if (fifo_read && (rp != wp)) begin
      fifo_data_out <= mem[rp];
      rp <= rp + 1;
    end
  end

  // stream monitor
  logic [15:0] got [$];
  int rd_cnt = 0;
  int viol   = 0;
  int pops2  = 0;

  always @(posedge clk) begin
    if (rst_) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (fifo_read) rd_cnt++;
      if (fifo_read && fifo_empty) viol++;
      if (out_valid2 && ready2) pops2++;
    end
  end

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    mem[wp] = v;
    wp = wp + 1;
  endtask

  // leaves rst_ low; caller releases it
  task automatic hold_reset();
    rst_ = 1'b0;
    en = 1'b0;
    out_ready = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
  endtask

  typedef struct {
    logic en;
    logic exp_read;
    logic exp_valid;
    logic exp_busy;
  } ctl_vec_t;

  typedef struct {
    logic [15:0] data;
    logic [15:0] cnt;
  } str_vec_t;

  ctl_vec_t ctl_tbl [8];
  str_vec_t str_tbl [16];

  initial begin
    int n;
    int base;
    int rb;
    int bad;
    rst_ = 1'b0;
    en = 1'b0;
    out_ready = 1'b0;
    en2 = 1'b0;
    ready2 = 1'b1;

    ctl_tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0};
    ctl_tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    ctl_tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
    ctl_tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1};
    ctl_tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    ctl_tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0};
    ctl_tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0};
    ctl_tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) begin
      str_tbl[i].data = 16'(i + 1);
      str_tbl[i].cnt  = 16'(i + 1);
    end

    // reset values
    hold_reset();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_read", fifo_read, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", word_cnt, 16'd0);
    chk("rst_data", out_data, 16'd0);

    // empty FIFO with enable: never read, never valid, busy once active
    out_ready = 1'b1;
    rst_ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      en = ctl_tbl[i].en;
      @(negedge clk);
      chk($sformatf("empty_read[%0d]", i), fifo_read, ctl_tbl[i].exp_read);
      chk($sformatf("empty_valid[%0d]", i), out_valid, ctl_tbl[i].exp_valid);
      chk($sformatf("empty_busy[%0d]", i), busy, ctl_tbl[i].exp_busy);
      step();
    end

    // streaming 0x0001..0x0010
    hold_reset();
    for (int i = 1; i <= 16; i++) load(16'(i));
    en = 1'b1;
    out_ready = 1'b1;
    rst_ = 1'b1;
    @(negedge clk);
    chk("first_edge_no_read", fifo_read, 1'b0);
    @(negedge clk);
    chk("second_edge_read", fifo_read, 1'b1);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stream_latency", n, 2);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("stream_valid[%0d]", i), out_valid, 1'b1);
      chk($sformatf("stream_data[%0d]", i), out_data, str_tbl[i].data);
      @(posedge clk);
      #1;
      chk($sformatf("stream_cnt[%0d]", i), word_cnt, str_tbl[i].cnt);
      @(negedge clk);
    end
    chk("stream_done_valid", out_valid, 1'b0);
    chk("stream_done_read", fifo_read, 1'b0);

    // backpressure: 8 words, downstream stalled 10 cycles
    hold_reset();
    for (int i = 0; i < 8; i++) load(16'h0100 + 16'(i));
    en = 1'b1;
    out_ready = 1'b0;
    base = rd_cnt;
    rst_ = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid && out_data !== 16'h0100) bad++;
      step();
    end
    chk("bp_reads", rd_cnt - base, 2);
    chk("bp_occ", u_dut.occ, 2'd2);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_hold", bad, 0);
    chk("bp_head", out_data, 16'h0100);
    base = got.size();
    out_ready = 1'b1;
    n = 0;
    while ((got.size() - base) < 8 && n < 30) begin
      step();
      n++;
    end
    chk("bp_count", got.size() - base, 8);
    for (int k = 0; k < 8; k++) begin
      if (base + k < got.size())
        chk($sformatf("bp_word[%0d]", k), got[base + k], 16'h0100 + 16'(k));
      else
        chk($sformatf("bp_word[%0d]", k), 32'hFFFF_FFFF, 16'h0100 + 16'(k));
    end

    // asynchronous reset mid-transfer with a full buffer
    for (int i = 0; i < 4; i++) load(16'h0300 + 16'(i));
    out_ready = 1'b0;
    repeat (5) step();
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_cnt", word_cnt, 16'd8);
    rst_ = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_read", fifo_read, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cnt", word_cnt, 16'd0);
    step();
    en = 1'b0;
    out_ready = 1'b1;
    rst_ = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
      step();
    end
    chk("post_rst_no_output", bad, 0);

    // drain: full buffer, one read issued, then en drops
    hold_reset();
    for (int i = 0; i < 8; i++) load(16'h0200 + 16'(i));
    en = 1'b1;
    out_ready = 1'b0;
    rst_ = 1'b1;
    repeat (6) step();
    chk("drain_occ", u_dut.occ, 2'd2);
    base = got.size();
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_last_read", fifo_read, 1'b1);
    step();
    en = 1'b0;
    rb = rd_cnt;
    n = 0;
    while (busy && n < 10) begin
      step();
      n++;
    end
    chk("drain_idle", busy, 1'b0);
    chk("drain_reads", rd_cnt - rb, 0);
    chk("drain_count", got.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      if (base + k < got.size())
        chk($sformatf("drain_word[%0d]", k), got[base + k], 16'h0200 + 16'(k));
      else
        chk($sformatf("drain_word[%0d]", k), 32'hFFFF_FFFF, 16'h0200 + 16'(k));
    end
    chk("drain_valid", out_valid, 1'b0);

    // counter wrap with a 4-bit counter
    pops2 = 0;
    en2 = 1'b1;
    ready2 = 1'b1;
    n = 0;
    while (pops2 < 17 && n < 60) begin
      step();
      n++;
    end
    ready2 = 1'b0;
    en2 = 1'b0;
    chk("wrap_pops", pops2, 17);
    chk("wrap_cnt", word_cnt2, 4'd1);

    chk("read_while_empty", viol, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
